// File: rtl/span_margin_accum.sv
// Portfolio margin accumulator: clamps each commodity's risk at zero, sums it with saturation, and reports the total.
// Optional macro SPAN_SOM_FLOOR_EN adds the som_floor port and applies max(acc, som_floor) to the result.
module span_margin_accum #(
  parameter int MAX_CC = 8,
  parameter int ACC_W  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_scan_risk,
  input  logic [15:0]      in_spread_chg,
  input  logic [15:0]      in_credit,
  input  logic             in_last,
`ifdef SPAN_SOM_FLOOR_EN
  input  logic [15:0]      som_floor,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_margin,
  output logic [3:0]       out_count,
  output logic             out_trunc
);

  localparam int DATA_W = 16;
  localparam int RISK_W = DATA_W + 1;
  localparam int SUM_W  = ((ACC_W > RISK_W) ? ACC_W : RISK_W) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, HOLD} state_t;

  state_t              state;
  logic [3:0]          count;
  logic                trunc;
  logic [ACC_W-1:0]    acc;
  logic [RISK_W-1:0]   risk_p0;
  logic                vld_p0;
  logic                end_p0;
  logic                accept;
  logic                ends;

  function automatic logic [RISK_W-1:0] clamp_risk(input logic [DATA_W-1:0] scan,
                                                   input logic [DATA_W-1:0] spread,
                                                   input logic [DATA_W-1:0] credit);
    logic signed [DATA_W+1:0] r;
    r = $signed({2'b00, scan}) + $signed({2'b00, spread}) - $signed({2'b00, credit});
    return r[DATA_W+1] ? '0 : r[RISK_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [RISK_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s[SUM_W-1:ACC_W] != '0) ? '1 : s[ACC_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] apply_floor(input logic [ACC_W-1:0] a,
                                                   input logic [DATA_W-1:0] fl);
    return (SUM_W'(fl) > SUM_W'(a)) ? ACC_W'(fl) : a;
  endfunction

  assign accept = in_valid && in_ready;
  assign ends   = in_last || ((count + 4'd1) == 4'(MAX_CC));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      count      <= '0;
      trunc      <= 1'b0;
      acc        <= '0;
      risk_p0    <= '0;
      vld_p0     <= 1'b0;
      end_p0     <= 1'b0;
      out_valid  <= 1'b0;
      out_margin <= '0;
      out_count  <= '0;
      out_trunc  <= 1'b0;
    end else begin
      // p0: clamp the accepted beat; in_ready drops the moment the portfolio closes
      vld_p0 <= accept;
      if (accept) begin
        risk_p0 <= clamp_risk(in_scan_risk, in_spread_chg, in_credit);
        end_p0  <= ends;
        count   <= count + 4'd1;
        if (ends) begin
          in_ready <= 1'b0;
          trunc    <= !in_last;
        end
      end
      // p1: fold the clamped risk into the saturating accumulator
      if (vld_p0)
        acc <= sat_add(acc, risk_p0);

      case (state)
        IDLE: begin
          in_ready <= !(accept && ends);
          if (accept)
            state <= ACCUM;
        end
        ACCUM: begin
          if (vld_p0 && end_p0)
            state <= FINAL;
        end
        FINAL: begin
`ifdef SPAN_SOM_FLOOR_EN
          out_margin <= apply_floor(acc, som_floor);
`else
          out_margin <= acc;
`endif
          out_count <= count;
          out_trunc <= trunc;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc       <= '0;
            count     <= '0;
            trunc     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPAN_SOM_FLOOR_EN
  logic unused_floor_fn;
  assign unused_floor_fn = ^apply_floor('0, '0);
`endif

endmodule

// File: tb/tb_span_margin_accum.sv
// Directed bench for span_margin_accum with a scoreboard of expected portfolio results.
module tb_span_margin_accum;
  localparam int MAX_CC = 8;
  localparam int ACC_W  = 16;
  localparam int MAXV   = 65535;
  localparam int FLOOR  = 400;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_scan_risk;
  logic [15:0]      in_spread_chg;
  logic [15:0]      in_credit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_margin;
  logic [3:0]       out_count;
  logic             out_trunc;
`ifdef SPAN_SOM_FLOOR_EN
  logic [15:0]      som_floor = 16'(FLOOR);
`endif

  always #5 clk = ~clk;

  span_margin_accum #(.MAX_CC(MAX_CC), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_scan_risk(in_scan_risk), .in_spread_chg(in_spread_chg),
    .in_credit(in_credit), .in_last(in_last),
`ifdef SPAN_SOM_FLOOR_EN
    .som_floor(som_floor),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_margin(out_margin), .out_count(out_count), .out_trunc(out_trunc)
  );

  typedef struct {int margin; int count; int trunc;} exp_t;
  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  int m_acc  = 0;
  int m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_beat(input int s, input int sp, input int cr, input bit last);
    exp_t e;
    int r;
    r = s + sp - cr;
    if (r < 0) r = 0;
    m_acc = m_acc + r;
    if (m_acc > MAXV) m_acc = MAXV;
    m_cnt++;
    if (last || m_cnt == MAX_CC) begin
      e.margin = m_acc;
`ifdef SPAN_SOM_FLOOR_EN
      if (e.margin < FLOOR) e.margin = FLOOR;
`endif
      e.count = m_cnt;
      e.trunc = last ? 0 : 1;
      sb.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int s, input int sp, input int cr, input bit last);
    in_scan_risk  = 16'(s);
    in_spread_chg = 16'(sp);
    in_credit     = 16'(cr);
    in_last       = last;
    in_valid      = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(posedge clk);
        model_beat(s, sp, cr, last);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    exp_t e;
    int i;
    i = 0;
    while (!out_valid && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_margin"}, out_margin, e.margin);
    chk({tag, "_count"},  out_count,  e.count);
    chk({tag, "_trunc"},  out_trunc,  e.trunc);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    in_scan_risk = '0; in_spread_chg = '0; in_credit = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_margin", out_margin, 0);
    chk("rst_count", out_count, 0);
    chk("rst_trunc", out_trunc, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Three-beat portfolio with latency check
    send(100, 10, 0, 0);
    send(200, 0, 50, 0);
    send(50, 5, 5, 1);
    chk("lat_t0", out_valid, 0);
    @(negedge clk);
    chk("lat_t1", out_valid, 0);
    @(negedge clk);
    chk("lat_t2", out_valid, 1);
    get_result("three");

    // Negative risk clamps to zero
    send(10, 0, 500, 1);
    get_result("clamp");

    // Truncation at MAX_CC, ninth beat held off
    for (int k = 0; k < MAX_CC; k++) send(1000, 0, 0, 0);
    chk("trunc_in_ready", in_ready, 0);
    in_scan_risk = 16'd1000; in_spread_chg = '0; in_credit = '0; in_last = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("trunc_hold_ready", in_ready, 0);
    chk("trunc_hold_count", out_count, MAX_CC);
    get_result("trunc");
    send(1000, 0, 0, 0);
    send(1000, 0, 0, 1);
    get_result("after_trunc");

    // Saturation at 2^ACC_W - 1
    send(65535, 65535, 0, 0);
    send(65535, 65535, 0, 1);
    get_result("sat");

    // Stall in HOLD, then reset drops the pending result
    send(300, 0, 0, 1);
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_margin", out_margin, (sb.size() > 0) ? sb[0].margin : -1);
      chk("stall_count", out_count, 1);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_margin", out_margin, 0);
    chk("midrst_in_ready", in_ready, 0);
    reset = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    m_acc = 0;
    m_cnt = 0;
    send(7, 0, 0, 1);
    get_result("post_rst");

    // Floor behaviour (100 without floor, FLOOR with it)
    send(100, 0, 0, 1);
    get_result("floor");

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/span_margin_accum.md
# span_margin_accum

Downstream consumer of the per-commodity scanning-risk stage. Takes one scanning-risk result per combined commodity, adds that commodity's intra-commodity spread charge, subtracts its inter-commodity credit, clamps at zero, and accumulates the results over one portfolio. The total portfolio margin is presented through a valid/ready output handshake to the reporting stage.

## Interface
- MAX_CC, 8: maximum number of commodity beats per portfolio (2..15).
- ACC_W, 24: width of the accumulator and the margin output.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_scan_risk  in  16  unsigned scanning risk of one commodity.
- in_spread_chg  in  16  unsigned intra-commodity spread charge.
- in_credit  in  16  unsigned inter-commodity spread credit.
- in_last  in  1  final beat of the portfolio.
- som_floor  in  16  unsigned short-option-minimum floor. Present only with SPAN_SOM_FLOOR_EN.
- out_valid  out  1  margin result valid.
- out_ready  in  1  downstream accepts the result.
- out_margin  out  ACC_W  total portfolio margin, unsigned.
- out_count  out  4  number of beats accumulated.
- out_trunc  out  1  portfolio was cut off at MAX_CC beats without in_last.

## Operation
- A beat is accepted when in_valid && in_ready.
- Per-beat risk:
  - r = in_scan_risk + in_spread_chg − in_credit, computed as 18-bit signed.
  - If r < 0, r = 0.
  - r is zero-extended to ACC_W.
- Accumulation: acc = acc + r, saturating at 2^ACC_W − 1. The sum never wraps.
- FSM states:
  - IDLE: in_ready = 1; acc = 0; count = 0.
  - ACCUM: in_ready = 1. An accepted beat updates acc and count.
  - FINAL: in_ready = 0. Floor is applied (see Configuration). Lasts 1 cycle.
  - HOLD: in_ready = 0; out_valid = 1. Outputs stay stable until out_ready.
- Transitions:
  - IDLE or ACCUM → ACCUM on an accepted beat with in_last = 0 and count+1 < MAX_CC.
  - IDLE or ACCUM → FINAL on an accepted beat with in_last = 1, or when count+1 == MAX_CC.
  - FINAL → HOLD unconditionally.
  - HOLD → IDLE when out_ready = 1.
- Truncation: when the MAX_CC-th beat arrives with in_last = 0, it is still accumulated and out_trunc is set. The next beats are held off by in_ready = 0 and start a new portfolio after HOLD.
- A 1-beat portfolio (in_last = 1 from IDLE) is legal.
- out_ready in any state other than HOLD is ignored.
- Reset mid-operation: the partial sum is discarded and any pending result is dropped.

## Timing
- Reset values: in_ready = 0 during reset, then 1 on the first cycle after reset deasserts. out_valid = 0, out_margin = 0, out_count = 0, out_trunc = 0.
- Latency: if the final beat is accepted at edge t, out_valid rises at edge t+2.
- Throughput: 1 beat/cycle while accumulating. Minimum gap between portfolios is 2 cycles (FINAL and HOLD) plus the downstream stall.
- Back-to-back: out_valid and out_ready both high in HOLD gives IDLE next cycle, with in_ready = 1 that cycle.
- out_valid never drops without out_ready. Outputs never change while out_valid = 1.

## Configuration
- SPAN_SOM_FLOOR_EN defined:
  - The som_floor port exists.
  - In FINAL, out_margin = max(acc, zero-extended som_floor).
- SPAN_SOM_FLOOR_EN undefined:
  - The som_floor port is absent.
  - In FINAL, out_margin = acc.

## Test plan
- Three beats (scan, spread, credit) = (100, 10, 0), (200, 0, 50), (50, 5, 5) with last on beat 3 → out_margin = 310, out_count = 3, out_trunc = 0, out_valid 2 cycles after beat 3.
- Single beat (10, 0, 500) with last → negative risk clamps: out_margin = 0, out_count = 1.
- MAX_CC = 8: 9 beats of (1000, 0, 0), never last → after beat 8: out_margin = 8000, out_trunc = 1, in_ready = 0. Beat 9 is accepted only after the handshake and starts a new portfolio.
- ACC_W = 16: beats of (65535, 65535, 0) ×2 with last → out_margin saturates at 65535.
- Hold out_ready = 0 for 5 cycles → out_valid stays high, outputs stable, in_ready = 0. Then pulse reset low in HOLD → out_valid = 0 and acc cleared the next cycle.
- With SPAN_SOM_FLOOR_EN, som_floor = 400, single beat (100, 0, 0) → out_margin = 400. Same stimulus without the macro → out_margin = 100.
